// File: rtl/te_branch_map.sv
// Purpose: accumulates the trace branch map (one bit per retired conditional branch, LSB first).
// Latency: one cycle from a sampled branch event to map_o/branches_o; flags decode the registered count.
// Backpressure: none; a branch arriving while the map is full is dropped and flagged in overflow_o.
//
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   iretire_i, itype_i  serialized retirement stream (itype 4 = not-taken branch, 5 = taken branch)
//   flush_i             emitter consumed the current map this cycle
//   map_o, branches_o   accumulated map and number of valid bits in it
//   is_full_o, is_empty_o, overflow_o  count decodes and sticky dropped-branch flag
module te_branch_map #(
    parameter int ITYPE_LEN    = 3,
    parameter int MAX_BRANCHES = 31,
    parameter int CNT_LEN      = $clog2(MAX_BRANCHES + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    iretire_i,
    input  logic [ITYPE_LEN-1:0]    itype_i,
    input  logic                    flush_i,
    output logic [MAX_BRANCHES-1:0] map_o,
    output logic [CNT_LEN-1:0]      branches_o,
    output logic                    is_full_o,
    output logic                    is_empty_o,
    output logic                    overflow_o
);

    localparam logic [ITYPE_LEN-1:0] ITYPE_BR_NT = ITYPE_LEN'(4);
    localparam logic [ITYPE_LEN-1:0] ITYPE_BR_TK = ITYPE_LEN'(5);
    localparam logic [CNT_LEN-1:0]   CNT_MAX     = CNT_LEN'(MAX_BRANCHES);

    logic [MAX_BRANCHES-1:0] map_q, map_d;
    logic [CNT_LEN-1:0]      cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;

    logic branch_evt;
    logic branch_bit;
    logic full;

    assign branch_evt = iretire_i && ((itype_i == ITYPE_BR_NT) || (itype_i == ITYPE_BR_TK));
    // Not-taken is encoded as 1, taken as 0.
    assign branch_bit = (itype_i == ITYPE_BR_NT);
    assign full       = (cnt_q == CNT_MAX);

    always_comb begin
        map_d = map_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (flush_i) begin
            // Flush discards the old contents; a simultaneous branch starts the new map.
            map_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            if (branch_evt) begin
                map_d[0] = branch_bit;
                cnt_d    = CNT_LEN'(1);
            end
        end else if (branch_evt) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                // Bits above the count are always 0, so OR-ing in the new bit is enough.
                map_d = map_q | (MAX_BRANCHES'(branch_bit) << cnt_q);
                cnt_d = cnt_q + CNT_LEN'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            map_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            map_q <= map_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign map_o      = map_q;
    assign branches_o = cnt_q;
    assign is_full_o  = full;
    assign is_empty_o = (cnt_q == '0);
    assign overflow_o = ovf_q;

endmodule

// File: doc/te_branch_map.md
Name: te_branch_map

Overview:
- Sits directly downstream of the multiple-retirement serializer, in parallel with the trace encoder's packet logic.
- Consumes the serialized one-instruction-per-cycle stream (iretire/itype) and accumulates the E-Trace branch map: one bit per retired conditional branch, LSB first.
- Exposes the map and the branch count to the packet emitter.
- Clears when the emitter signals that the map has been consumed in a packet.

Parameters:
- ITYPE_LEN, 3, width of itype field (matches mure_pkg::ITYPE_LEN).
- MAX_BRANCHES, 31, capacity of the branch map in bits (E-Trace maximum).
- CNT_LEN, $clog2(MAX_BRANCHES+1), width of the branch counter (5 at default).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- iretire_i  in  1  instruction retired this cycle (from serializer iretire_o)
- itype_i  in  ITYPE_LEN  type of the retired instruction; 4 = not-taken branch, 5 = taken branch, others ignored
- flush_i  in  1  packet emitter consumed the current map this cycle
- map_o  out  MAX_BRANCHES  branch map; bit k = k-th branch since last flush; 1 = not taken, 0 = taken
- branches_o  out  CNT_LEN  number of valid bits in map_o
- is_full_o  out  1  branches_o == MAX_BRANCHES
- is_empty_o  out  1  branches_o == 0
- overflow_o  out  1  sticky; a branch arrived while full and was dropped

Behaviour:
- All outputs registered. Reset (rst_i=1 at a clk_i edge) forces: map_o=0, branches_o=0, is_full_o=0, is_empty_o=1, overflow_o=0.
- Reset wins over every other input in the same cycle, including mid-accumulation.
- A branch event is iretire_i=1 and itype_i in {4,5}. The bit value is 1 for itype 4 and 0 for itype 5.
- iretire_i=0 means itype_i is don't-care. Non-branch itypes leave the state unchanged.
- Latency: an event sampled at edge N is visible on map_o/branches_o after edge N (one-cycle latency).
- Event only, not full:
  - map[branches] <= bit; branches <= branches+1.
  - Bits at index >= branches stay 0.
- flush_i only:
  - map <= 0; branches <= 0; overflow <= 0.
- flush_i and branch event in the same cycle:
  - The flush applies to the old contents.
  - The new branch lands at bit 0: map <= {0..., bit}; branches <= 1; overflow <= 0.
- Event while full (branches == MAX_BRANCHES) and no flush:
  - The branch is dropped.
  - map and branches are unchanged; overflow <= 1 (sticky until flush or reset).
- Event while full with flush in the same cycle: handled as flush-and-event. No overflow.
- Flag derivation:
  - is_full_o and is_empty_o are combinational decodes of the registered counter, so they are consistent with branches_o in the same cycle.
  - is_full_o and is_empty_o are never both 1.
- Counter never wraps. The maximum value is MAX_BRANCHES; 0 is reached only by flush or reset.
- No internal state machine beyond the counter and sticky flag. States are implicitly EMPTY (cnt=0), PARTIAL (0<cnt<MAX), FULL (cnt=MAX).
  - EMPTY->PARTIAL on an event.
  - PARTIAL->FULL on the event reaching MAX.
  - any->EMPTY on flush without an event.
  - any->PARTIAL(cnt=1) on flush with an event.

Test Plan:
- Reset then idle 5 cycles -> map_o=0, branches_o=0, is_empty_o=1, is_full_o=0, overflow_o=0.
- Retire itype 4,5,4,5,4 on consecutive cycles, with itype 0 and iretire_i=0 cycles interleaved -> map_o=0x15, branches_o=5, unchanged by the non-branch cycles.
- 31 consecutive itype 4 -> map_o=0x7FFFFFFF, branches_o=31, is_full_o=1. A 32nd itype 5 -> state unchanged, overflow_o=1. flush_i -> all cleared, overflow_o=0.
- 3 branches (4,4,5), then flush_i with a simultaneous itype 5 -> next cycle map_o=0x0, branches_o=1; then itype 4 -> map_o=0x2, branches_o=2.
- Full map, then flush_i with a simultaneous itype 4 -> map_o=0x1, branches_o=1, overflow_o=0, is_full_o=0.
- 10 branches accumulated, then rst_i with a simultaneous branch and flush -> all outputs at reset values the next cycle.
